// File: rtl/output_forward.sv
// Forward-pass output neuron: accumulates N_HIDDEN activation x weight products into a 23-bit result.
// Build option: define OUTPUT_FORWARD_SAT_EN to saturate final_o on overflow instead of wrapping.
module output_forward #(
    parameter int N_HIDDEN = 4,
    parameter int IDX_W    = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [9:0]       hidden_val_i,
    input  logic             hidden_valid_i,
    output logic             hidden_ready_o,
    output logic [IDX_W-1:0] w_idx_o,
    input  logic [7:0]       w_i,
    output logic [22:0]      final_o,
    output logic             f_end_o,
    output logic             busy_o,
    output logic             ovf_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [23:0]      acc;
    logic [IDX_W-1:0] idx;
    logic             xfer;
    logic             last;
    logic [17:0]      prod;
    logic [23:0]      sum;
    logic [22:0]      result;

    assign hidden_ready_o = (state == S_ACCUM);
    assign w_idx_o        = idx;
    assign xfer           = hidden_valid_i & hidden_ready_o;
    assign last           = (idx == IDX_W'(N_HIDDEN - 1));
    assign prod           = {8'd0, hidden_val_i} * {10'd0, w_i};
    // sum cannot exceed 2^24 for N_HIDDEN <= 64, so bit 23 is the overflow flag
    assign sum            = acc + {6'd0, prod};

`ifdef OUTPUT_FORWARD_SAT_EN
    assign result = sum[23] ? '1 : sum[22:0];
`else
    assign result = sum[22:0];
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= S_IDLE;
            acc     <= '0;
            idx     <= '0;
            final_o <= '0;
            ovf_o   <= 1'b0;
            f_end_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        acc    <= '0;
                        idx    <= '0;
                        busy_o <= 1'b1;
                        state  <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (xfer) begin
                        acc <= sum;
                        idx <= idx + 1'b1;
                        if (last) begin
                            final_o <= result;
                            ovf_o   <= sum[23];
                            f_end_o <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    f_end_o <= 1'b0;
                    busy_o  <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    f_end_o <= 1'b0;
                    busy_o  <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_forward.sv
// Scoreboard bench for output_forward: randomized passes checked against a sum-of-products reference.
module tb_output_forward;

    localparam int N  = 4;
    localparam int IW = 6;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i, start_i, hv_valid, hready, f_end, busy, ovf;
    logic [9:0]    hv;
    logic [IW-1:0] widx;
    logic [7:0]    w;
    logic [22:0]   final_v;
    logic [7:0]    wtab [64];
    logic [9:0]    vtab [64];

    assign w = wtab[widx];

    output_forward #(.N_HIDDEN(N), .IDX_W(IW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .hidden_val_i(hv),
        .hidden_valid_i(hv_valid), .hidden_ready_o(hready), .w_idx_o(widx), .w_i(w),
        .final_o(final_v), .f_end_o(f_end), .busy_o(busy), .ovf_o(ovf)
    );

    // Second instance exercises the 64-input overflow corner with maximal operands.
    logic          start2, hready2, f_end2, busy2, ovf2;
    logic [5:0]    widx2;
    logic [22:0]   final2;

    output_forward #(.N_HIDDEN(64), .IDX_W(6)) dut64 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start2), .hidden_val_i(10'd1023),
        .hidden_valid_i(1'b1), .hidden_ready_o(hready2), .w_idx_o(widx2), .w_i(8'd255),
        .final_o(final2), .f_end_o(f_end2), .busy_o(busy2), .ovf_o(ovf2)
    );

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [22:0] f;
        logic        o;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_model(input int unsigned s);
        exp_t e;
        e.o = (s >= 32'd8388608);
`ifdef OUTPUT_FORWARD_SAT_EN
        e.f = e.o ? 23'h7FFFFF : 23'(s);
`else
        e.f = 23'(s % 32'd8388608);
`endif
        return e;
    endfunction

    // Monitor: pops expectations on each completion strobe and checks handshake timing.
    logic [22:0] held_f;
    logic        held_o, prev_fire, prev_fend, fire;
    int          xcnt;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_i) begin
            held_f = '0; held_o = 1'b0; xcnt = 0; prev_fire = 1'b0; prev_fend = 1'b0;
        end else begin
            if (f_end) begin
                check("f_end_follows_last_xfer", 32'(prev_fire), 32'd1);
                check("busy_in_done", 32'(busy), 32'd1);
                if (sbq.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_f_end: got final %0d expected no completion", final_v);
                end else begin
                    e = sbq.pop_front();
                    check("final_o", 32'(final_v), 32'(e.f));
                    check("ovf_o", 32'(ovf), 32'(e.o));
                    held_f = e.f; held_o = e.o;
                end
                xcnt = 0;
            end else begin
                check("final_held", 32'(final_v), 32'(held_f));
                check("ovf_held", 32'(ovf), 32'(held_o));
            end
            if (prev_fend) check("f_end_busy_fall", {30'd0, f_end, busy}, 32'd0);
            check("ready_only_in_accum", 32'(hready), 32'(busy & ~f_end));
            fire = hready & hv_valid;
            if (fire) begin
                check("w_idx_o", 32'(widx), 32'(xcnt % 64));
                xcnt++;
            end
            prev_fire = fire;
            prev_fend = f_end;
        end
    end

    task automatic run_pass(input int stall_max, input bit noise, input int abort_after);
        int unsigned s = 0;
        int          k = 0;
        int          budget = 0;
        bit          f;
        for (int i = 0; i < N; i++) s += vtab[i] * wtab[i];
        if (abort_after < 0) sbq.push_back(ref_model(s));
        if (noise) begin
            hv_valid = 1'b1; hv = 10'($urandom);
            repeat (2) @(posedge clk);
            #1;
        end
        start_i = 1'b1; hv_valid = 1'b0;
        @(posedge clk); #1;
        start_i = noise;
        while (k < N) begin
            budget++;
            if (budget > 1000) begin
                compared++; mismatched++;
                $display("FAIL pass_timeout: got %0d transfers expected %0d", k, N);
                break;
            end
            if (stall_max > 0 && $urandom_range(0, 1) == 1) begin
                hv_valid = 1'b0; hv = 10'($urandom);
                repeat ($urandom_range(1, stall_max)) @(posedge clk);
                #1;
                continue;
            end
            hv_valid = 1'b1; hv = vtab[k];
            @(negedge clk); f = hready;
            @(posedge clk); #1;
            if (f) begin
                k++;
                if (k == abort_after) begin
                    rst_i = 1'b0;
                    #1;
                    check("rst_final", 32'(final_v), 32'd0);
                    check("rst_ovf", 32'(ovf), 32'd0);
                    check("rst_f_end", 32'(f_end), 32'd0);
                    check("rst_busy", 32'(busy), 32'd0);
                    check("rst_ready", 32'(hready), 32'd0);
                    check("rst_w_idx", 32'(widx), 32'd0);
                    hv_valid = 1'b0; start_i = 1'b0;
                    @(posedge clk); #1;
                    rst_i = 1'b1;
                    return;
                end
            end
        end
        hv_valid = noise; start_i = noise;
        @(posedge clk); #1;
        start_i = 1'b0; hv_valid = 1'b0;
    endtask

    task automatic load_basic();
        for (int i = 0; i < 64; i++) begin
            vtab[i] = 10'(i + 1);
            wtab[i] = 8'(10 * (i + 1));
        end
    endtask

    task automatic load_random();
        for (int i = 0; i < 64; i++) begin
            vtab[i] = ($urandom_range(0, 3) == 0) ? 10'd1023 : 10'($urandom_range(0, 1023));
            wtab[i] = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
        end
    endtask

    initial begin
        int b;
        rst_i = 1'b0; start_i = 1'b0; hv_valid = 1'b0; hv = '0; start2 = 1'b0;
        load_basic();
        #12;
        check("reset_final", 32'(final_v), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(hready), 32'd0);
        check("reset_w_idx", 32'(widx), 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;

        run_pass(0, 1'b0, -1);          // basic: 300
        run_pass(3, 1'b0, -1);          // stalls
        run_pass(0, 1'b1, -1);          // ignored start/valid
        load_random();
        run_pass(1, 1'b0, -1);
        run_pass(0, 1'b0, 2);           // reset after 2 transfers
        load_basic();
        run_pass(0, 1'b0, -1);          // fresh pass after reset: 300
        load_random();
        run_pass(0, 1'b0, -1);          // back-to-back
        load_random();
        run_pass(0, 1'b0, -1);
        for (int p = 0; p < 20; p++) begin
            load_random();
            run_pass($urandom_range(0, 4), 1'($urandom_range(0, 1)), -1);
        end
        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);

        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        b = 0;
        while (f_end2 !== 1'b1 && b < 200) begin
            @(posedge clk); #1;
            b++;
        end
        if (b >= 200) begin
            compared++; mismatched++;
            $display("FAIL overflow_timeout: got no f_end expected one within 200 cycles");
        end else begin
`ifdef OUTPUT_FORWARD_SAT_EN
            check("overflow_final", 32'(final2), 32'd8388607);
`else
            check("overflow_final", 32'(final2), 32'd8306752);
`endif
            check("overflow_ovf", 32'(ovf2), 32'd1);
            check("overflow_cycles", 32'(b), 32'd64);
        end
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/output_forward.md
# output_forward

Forward-pass output neuron: the producer of the 23-bit `final` value that the output backprop stage consumes. After a start pulse, it streams `N_HIDDEN` hidden-layer activations through a valid/ready handshake. For each activation it supplies a weight-fetch index, multiplies the activation by the returned 8-bit weight, and accumulates the products. It then presents the 23-bit result with a one-cycle completion strobe, which the sequencing state machine uses to enter the backward pass.

## Interface
Parameters:
- `N_HIDDEN`, default 4: number of hidden activations accumulated per pass; legal range 1..64.
- `IDX_W`, default 6: width of the weight index; must satisfy 2^IDX_W ≥ N_HIDDEN.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  starts a pass; sampled only in IDLE.
- `hidden_val_i`  in  10  unsigned hidden activation.
- `hidden_valid_i`  in  1  `hidden_val_i` is valid.
- `hidden_ready_o`  out  1  block accepts an activation this cycle.
- `w_idx_o`  out  IDX_W  index of the weight the block needs now.
- `w_i`  in  8  unsigned weight for `w_idx_o`; combinational fetch, same cycle.
- `final_o`  out  23  unsigned result of the last completed pass.
- `f_end_o`  out  1  one-cycle strobe: `final_o` has just been updated.
- `busy_o`  out  1  high in ACCUM and DONE.
- `ovf_o`  out  1  overflow flag from the last completed pass.

## Operation
- States:
  - IDLE: on `start_i`=1, `acc` := 0 and `idx` := 0; go to ACCUM.
  - ACCUM: after `N_HIDDEN` handshakes, go to DONE.
  - DONE: lasts one cycle, then go to IDLE.
- Handshake:
  - `hidden_ready_o` = 1 only in ACCUM.
  - A transfer occurs on a clock edge with `hidden_valid_i` & `hidden_ready_o`.
  - On a transfer: `acc` += `hidden_val_i` × `w_i`, and `idx` += 1.
  - `hidden_valid_i` may drop at any time; stalls are unbounded.
- `w_idx_o` = `idx` in every state (0 in IDLE after reset).
- Arithmetic:
  - The product is 18-bit unsigned, zero-extended.
  - `acc` is 24 bits; it cannot wrap for N_HIDDEN ≤ 64, because the maximum is 64 × 1023 × 255 = 16,695,360 < 2^24.
- Completion:
  - Completion is the edge of the N_HIDDEN-th transfer.
  - On that edge: `final_o` := result(`acc` + last product), and `ovf_o` := that sum ≥ 2^23.
  - `f_end_o` = 1 while in DONE.
- `final_o` and `ovf_o` hold their values until the next completion. They are not cleared by `start_i`.
- Boundary cases:
  - `start_i` in ACCUM or DONE is ignored.
  - `hidden_valid_i` in IDLE or DONE is ignored; no transfer occurs.
  - With N_HIDDEN = 1, the block completes on the first transfer.
- Reset, including mid-pass, acts asynchronously and forces:
  - state IDLE;
  - `acc`, `idx`, `final_o`, `ovf_o`, `f_end_o`, `busy_o`, `hidden_ready_o` all 0;
  - `w_idx_o` = 0.
  - A partially accumulated pass is discarded.

## Timing
- The start edge is the edge at which IDLE samples `start_i` = 1.
- `hidden_ready_o` is first high in the cycle after the start edge.
- With no stalls: start edge at cycle 0, transfers at edges 1..N, `f_end_o` high during cycle N+1, IDLE at cycle N+2.
- The earliest next start edge is at N+2, giving a throughput of one pass per N_HIDDEN + 2 cycles.
- `f_end_o` is exactly one cycle wide. `busy_o` falls in the same cycle that `f_end_o` falls.
- All outputs are registered except `hidden_ready_o` and `w_idx_o`, which decode directly from registers.

## Configuration
- `OUTPUT_FORWARD_SAT_EN` defined: if the 24-bit sum is ≥ 2^23, `final_o` = 23'h7FFFFF (saturated).
- `OUTPUT_FORWARD_SAT_EN` undefined: `final_o` = sum[22:0] (wrap modulo 2^23).
- `ovf_o` behaves identically in both builds.

## Test plan
- Basic sum: N_HIDDEN = 4; activations 1, 2, 3, 4 with weights 10, 20, 30, 40 and no stalls → `f_end_o` high exactly at cycle 5; `final_o` = 300; `ovf_o` = 0; `w_idx_o` sequence 0, 1, 2, 3.
- Stalls: same data as the basic case with `hidden_valid_i` low for 3 cycles between each transfer → `final_o` = 300; `idx` advances only on transfers.
- Overflow: N_HIDDEN = 64; all activations 1023 and all weights 255 → `ovf_o` = 1; `final_o` = 8,388,607 with `OUTPUT_FORWARD_SAT_EN`, 8,306,752 without it.
- Ignored inputs: `start_i` asserted during ACCUM and DONE, and `hidden_valid_i` held high in IDLE → no restart and no extra accumulation; the basic-sum result is unchanged.
- Reset mid-pass: `rst_i` low after 2 transfers → all outputs 0 immediately; a fresh pass then yields 300 with no residue.
- Back-to-back passes: `start_i` at cycle N+2 with new data → the second result is correct; `final_o` holds the first result until the second completion edge.
